// File: rtl/ysyx_23060240_bru.sv
// Branch resolution unit: resolves RV32I conditional branches, checks the frontend
// prediction and holds the result in one registered slot behind a valid/ready handshake.
module ysyx_23060240_bru #(
   parameter int XLEN       = 32,
   parameter int CNT_W      = 32,
   parameter int ILEN_BYTES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [2:0]       in_branch_type,
   input  logic             in_pred_taken,
   input  logic [XLEN-1:0]  in_pred_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_target,
   output logic [XLEN-1:0]  out_redirect_pc,
   output logic             out_mispredict,
   output logic [CNT_W-1:0] perf_branch_cnt,
   output logic [CNT_W-1:0] perf_mispred_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e          state, state_nxt;
   logic            in_xfer, out_xfer;
   logic            taken_nxt, mispredict_nxt, is_branch_nxt;
   logic [XLEN-1:0] target_nxt, fallthrough_nxt, redirect_nxt;
   logic            held_is_branch;

   assign in_ready = !out_valid || out_ready;
   assign in_xfer  = in_valid && in_ready && !flush;
   assign out_xfer = out_valid && out_ready;

   // Branch condition and next-PC arithmetic; all sums wrap modulo 2^XLEN.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      taken_nxt     = 1'b0;
      is_branch_nxt = 1'b1;
      case (in_branch_type)
         3'b001:  taken_nxt = (in_rs1 == in_rs2);
         3'b010:  taken_nxt = (in_rs1 != in_rs2);
         3'b011:  taken_nxt = ($signed(in_rs1) <  $signed(in_rs2));
         3'b100:  taken_nxt = ($signed(in_rs1) >= $signed(in_rs2));
         3'b101:  taken_nxt = (in_rs1 <  in_rs2);
         3'b110:  taken_nxt = (in_rs1 >= in_rs2);
         default: is_branch_nxt = 1'b0;
      endcase
      target_nxt      = in_pc + in_imm;
      fallthrough_nxt = in_pc + XLEN'(ILEN_BYTES);
      redirect_nxt    = taken_nxt ? target_nxt : fallthrough_nxt;
      mispredict_nxt  = (taken_nxt != in_pred_taken) ||
                        (taken_nxt && (in_pred_target != target_nxt));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   // Flush outranks both transfers; a simultaneous in/out transfer stays FULL.
   always_comb begin
      state_nxt = state;
      if (flush)         state_nxt = EMPTY;
      else if (in_xfer)  state_nxt = FULL;
      else if (out_xfer) state_nxt = EMPTY;
   end

   always_comb begin
      out_valid = (state == FULL);
   end

   // Result slot only loads on an input transfer, which keeps it stable under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the result slot is reset (not left undefined) so outputs read zero out of reset.
      if (!rst_n) begin
         out_taken       <= 1'b0;
         out_target      <= '0;
         out_redirect_pc <= '0;
         out_mispredict  <= 1'b0;
         held_is_branch  <= 1'b0;
      end else if (in_xfer) begin
         out_taken       <= taken_nxt;
         out_target      <= target_nxt;
         out_redirect_pc <= redirect_nxt;
         out_mispredict  <= mispredict_nxt;
         held_is_branch  <= is_branch_nxt;
      end
   end

   // Only real branches that actually retire are counted; flushed results are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branch_cnt  <= '0;
         perf_mispred_cnt <= '0;
      end else if (out_xfer && !flush && held_is_branch) begin
         if (perf_branch_cnt != '1)
            perf_branch_cnt <= perf_branch_cnt + 1'b1;
         if (out_mispredict && (perf_mispred_cnt != '1))
            perf_mispred_cnt <= perf_mispred_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ysyx_23060240_bru.sv
// Self-checking bench for ysyx_23060240_bru: a transaction-level model of the result
// slot and counters is compared every cycle, plus hand-computed directed expectations.
module tb_ysyx_23060240_bru;

   localparam int XLEN = 32;
   localparam int CW   = 4;
   localparam logic [CW-1:0] CMAX = '1;

   logic            clk = 1'b0;
   logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [XLEN-1:0] in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
   logic [2:0]      in_branch_type;
   logic            in_pred_taken, out_taken, out_mispredict;
   logic [XLEN-1:0] out_target, out_redirect_pc;
   logic [CW-1:0]   perf_branch_cnt, perf_mispred_cnt;

   int checks = 0;
   int errors = 0;

   ysyx_23060240_bru #(.XLEN(XLEN), .CNT_W(CW), .ILEN_BYTES(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
      .in_branch_type(in_branch_type), .in_pred_taken(in_pred_taken),
      .in_pred_target(in_pred_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_target(out_target),
      .out_redirect_pc(out_redirect_pc), .out_mispredict(out_mispredict),
      .perf_branch_cnt(perf_branch_cnt), .perf_mispred_cnt(perf_mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit resolve(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (t)
         3'd1: return a == b;
         3'd2: return a != b;
         3'd3: return sa < sb;
         3'd4: return sa >= sb;
         3'd5: return a < b;
         3'd6: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   bit        m_valid, m_taken, m_misp, m_isbr;
   bit [31:0] m_target, m_redirect;
   int        m_bcnt, m_mcnt;

   always @(posedge clk or negedge rst_n) begin
      bit ready, take_in, take_out, t;
      if (!rst_n) begin
         m_valid = 0; m_taken = 0; m_misp = 0; m_isbr = 0;
         m_target = 0; m_redirect = 0; m_bcnt = 0; m_mcnt = 0;
      end else begin
         ready    = !m_valid || out_ready;
         take_in  = in_valid && ready && !flush;
         take_out = m_valid && out_ready;
         if (flush) m_valid = 0;
         else begin
            if (take_out && m_isbr) begin
               if (m_bcnt < CMAX) m_bcnt++;
               if (m_misp && m_mcnt < CMAX) m_mcnt++;
            end
            if (take_in) begin
               t          = resolve(in_branch_type, in_rs1, in_rs2);
               m_isbr     = (in_branch_type != 3'd0) && (in_branch_type != 3'd7);
               m_taken    = t;
               m_target   = in_pc + in_imm;
               m_redirect = t ? in_pc + in_imm : in_pc + 32'd4;
               m_misp     = (t != in_pred_taken) || (t && in_pred_target != in_pc + in_imm);
               m_valid    = 1;
            end else if (take_out) m_valid = 0;
         end
      end
   end

   // One compare process, sampling on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
         check("branch_cnt", 32'(perf_branch_cnt), 32'(m_bcnt));
         check("mispred_cnt", 32'(perf_mispred_cnt), 32'(m_mcnt));
         if (m_valid) begin
            check("out_taken", 32'(out_taken), 32'(m_taken));
            check("out_target", out_target, m_target);
            check("out_redirect", out_redirect_pc, m_redirect);
            check("out_mispredict", 32'(out_mispredict), 32'(m_misp));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt);
      in_valid = 1'b1; in_branch_type = t; in_rs1 = a; in_rs2 = b;
      in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
   endtask

   task automatic expect_out(input string tag, input logic tk, input logic [31:0] tgt,
                             input logic [31:0] rd, input logic mp);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_taken"}, 32'(out_taken), 32'(tk));
      check({tag, "_target"}, out_target, tgt);
      check({tag, "_redirect"}, out_redirect_pc, rd);
      check({tag, "_misp"}, 32'(out_mispredict), 32'(mp));
   endtask

   task automatic expect_cnt(input string tag, input int b, input int m);
      check({tag, "_bcnt"}, 32'(perf_branch_cnt), b);
      check({tag, "_mcnt"}, 32'(perf_mispred_cnt), m);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; drive(3'd0, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_target", out_target, 32'd0);
      tick(); rst_n = 1'b1; #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      expect_cnt("rst", 0, 0);

      // beq equal, correctly predicted
      drive(3'd1, 32'h5, 32'h5, 32'h8000_0000, 32'h10, 1'b1, 32'h8000_0010);
      tick(); in_valid = 1'b0;
      expect_out("beq", 1'b1, 32'h8000_0010, 32'h8000_0010, 1'b0);
      tick();
      expect_cnt("beq", 1, 0);

      // blt (signed -1 < 1) then bltu (0xFFFFFFFF < 1 false), back to back
      drive(3'd3, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'h40, 1'b0, 32'h0);
      tick();
      expect_out("blt", 1'b1, 32'h1040, 32'h1040, 1'b1);
      drive(3'd5, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'h40, 1'b0, 32'h0);
      tick(); in_valid = 1'b0;
      expect_out("bltu", 1'b0, 32'h1040, 32'h1004, 1'b0);
      tick();
      expect_cnt("bltu", 3, 1);

      // bge with wrapping target, predicted target wrong
      drive(3'd4, 32'h7, 32'h7, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h0);
      tick(); in_valid = 1'b0;
      expect_out("bge_wrap", 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b1);
      tick();
      expect_cnt("bge_wrap", 4, 2);

      // back-pressure: A held for 3 cycles while B waits, then both transfer together
      out_ready = 1'b0;
      drive(3'd1, 32'h1, 32'h2, 32'h200, 32'h8, 1'b0, 32'h0);
      tick();
      drive(3'd2, 32'h1, 32'h2, 32'h300, 32'hFFFF_FFF8, 1'b1, 32'h2F8);
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", 32'(in_ready), 32'd0);
         expect_out("bp_hold", 1'b0, 32'h208, 32'h204, 1'b0);
         tick();
      end
      out_ready = 1'b1; #1;
      check("bp_release_ready", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      expect_out("bp_new", 1'b1, 32'h2F8, 32'h2F8, 1'b0);
      expect_cnt("bp_once", 5, 2);
      tick();
      expect_cnt("bp_drain", 6, 2);

      // flush while FULL with both transfers pending
      out_ready = 1'b0;
      drive(3'd1, 32'h3, 32'h3, 32'h400, 32'h4, 1'b0, 32'h0);
      tick();
      out_ready = 1'b1; flush = 1'b1;
      drive(3'd2, 32'h3, 32'h4, 32'h500, 32'h4, 1'b0, 32'h0);
      tick(); flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", 32'(out_valid), 32'd0);
      expect_cnt("flush", 6, 2);
      tick();
      check("flush_no_capture", 32'(out_valid), 32'd0);

      // not-a-branch types: never counted, pred_taken=1 still mispredicts
      drive(3'd0, 32'h1, 32'h1, 32'h600, 32'h40, 1'b1, 32'h640);
      tick();
      expect_out("nb0", 1'b0, 32'h640, 32'h604, 1'b1);
      drive(3'd7, 32'h1, 32'h1, 32'h700, 32'h40, 1'b0, 32'h0);
      tick(); in_valid = 1'b0;
      expect_out("nb7", 1'b0, 32'h740, 32'h704, 1'b0);
      tick();
      expect_cnt("nb", 6, 2);

      // saturation: 17 taken beq predicted not-taken
      rst_n = 1'b0; #2; rst_n = 1'b1;
      tick();
      for (int i = 0; i < 17; i++) begin
         drive(3'd1, i, i, 32'h1000 + 32'(i * 4), 32'h80, 1'b0, 32'h0);
         tick();
      end
      in_valid = 1'b0;
      tick();
      expect_cnt("sat", 15, 15);

      // asynchronous reset mid-stream
      drive(3'd1, 32'h9, 32'h9, 32'h2000, 32'h8, 1'b1, 32'h2008);
      tick();
      drive(3'd2, 32'h9, 32'h8, 32'h2100, 32'h8, 1'b0, 32'h0);
      @(posedge clk); #3;
      rst_n = 1'b0; #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_taken", 32'(out_taken), 32'd0);
      check("arst_target", out_target, 32'd0);
      check("arst_redirect", out_redirect_pc, 32'd0);
      check("arst_misp", 32'(out_mispredict), 32'd0);
      expect_cnt("arst", 0, 0);
      in_valid = 1'b0;
      tick(); rst_n = 1'b1;
      tick(); tick();
      expect_cnt("post_arst", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
